// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream arbiter: packet-aware grants bounded by MAX_BURST, registered tagged output.
// Optional stability checker on the granted source under `AXIS_ARB_PROTOCOL_CHECK_EN.
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 10,
  parameter int NUM_INPUTS = 4,
  parameter int SRC_WIDTH  = $clog2(NUM_INPUTS),
  parameter int MAX_BURST  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS-1:0]            input_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] input_data,
  input  logic [NUM_INPUTS-1:0]            input_last,
  output logic [NUM_INPUTS-1:0]            input_ready,
  output logic                             output_valid,
  output logic [DATA_WIDTH-1:0]            output_data,
  output logic                             output_last,
  output logic [SRC_WIDTH-1:0]             output_source,
  input  logic                             output_ready,
  output logic                             protocol_error
);

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [SRC_WIDTH-1:0]    grant_q, grant_d;
  logic [7:0]              burst_cnt_q, burst_cnt_d;
  logic                    output_valid_q, output_valid_d;
  logic [DATA_WIDTH-1:0]   output_data_q, output_data_d;
  logic                    output_last_q, output_last_d;
  logic [SRC_WIDTH-1:0]    output_source_q, output_source_d;

  logic                    slot_free;
  logic                    sel_valid;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_last;
  logic                    accept;
  logic [7:0]              burst_inc;
  logic                    scan_found;
  logic [SRC_WIDTH-1:0]    scan_idx;
  logic [SRC_WIDTH-1:0]    cand;

  // Modulo-NUM_INPUTS add so non-power-of-two source counts wrap correctly.
  function automatic logic [SRC_WIDTH-1:0] wrap_add(input logic [SRC_WIDTH-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_INPUTS) s = s - NUM_INPUTS;
    return SRC_WIDTH'(s);
  endfunction

  // grant_q doubles as the round-robin pointer: the scan always starts just after the last grant.
  assign slot_free = !output_valid_q || output_ready;
  assign sel_valid = input_valid[grant_q];
  assign sel_data  = input_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_last  = input_last[grant_q];
  assign accept    = (state_q == GRANTED) && sel_valid && slot_free;
  assign burst_inc = burst_cnt_q + 8'd1;

  // Iterate farthest-first so the nearest requester after the pointer wins.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    cand       = '0;
    for (int k = NUM_INPUTS; k >= 1; k--) begin
      cand = wrap_add(grant_q, k);
      if (input_valid[cand]) begin
        scan_found = 1'b1;
        scan_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      grant_q         <= SRC_WIDTH'(NUM_INPUTS - 1);
      burst_cnt_q     <= '0;
      output_valid_q  <= 1'b0;
      output_data_q   <= '0;
      output_last_q   <= 1'b0;
      output_source_q <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      burst_cnt_q     <= burst_cnt_d;
      output_valid_q  <= output_valid_d;
      output_data_q   <= output_data_d;
      output_last_q   <= output_last_d;
      output_source_q <= output_source_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    burst_cnt_d     = burst_cnt_q;
    output_valid_d  = output_valid_q && !output_ready;
    output_data_d   = output_data_q;
    output_last_d   = output_last_q;
    output_source_d = output_source_q;
    case (state_q)
      IDLE: begin
        if (scan_found) begin
          state_d     = GRANTED;
          grant_d     = scan_idx;
          burst_cnt_d = '0;
        end
      end
      GRANTED: begin
        if (accept) begin
          burst_cnt_d     = burst_inc;
          output_valid_d  = 1'b1;
          output_data_d   = sel_data;
          output_last_d   = sel_last;
          output_source_d = grant_q;
          // Forced rotate on burst limit leaves output_last as the source drove it.
          if (sel_last || (burst_inc == 8'(MAX_BURST))) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    input_ready = '0;
    if ((state_q == GRANTED) && slot_free) input_ready[grant_q] = 1'b1;
  end

  assign output_valid  = output_valid_q;
  assign output_data   = output_data_q;
  assign output_last   = output_last_q;
  assign output_source = output_source_q;

`ifdef AXIS_ARB_PROTOCOL_CHECK_EN
  logic                  hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_last_q, hold_last_d;
  logic                  protocol_error_q, protocol_error_d;
  logic                  violation;

  // A stalled beat must be re-presented unchanged until it is accepted.
  always_comb begin
    hold_vld_d       = (state_q == GRANTED) && sel_valid && !slot_free;
    hold_data_d      = sel_data;
    hold_last_d      = sel_last;
    violation        = hold_vld_q && (!sel_valid || (sel_data != hold_data_q) || (sel_last != hold_last_q));
    protocol_error_d = protocol_error_q || violation;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld_q       <= 1'b0;
      hold_data_q      <= '0;
      hold_last_q      <= 1'b0;
      protocol_error_q <= 1'b0;
    end else begin
      hold_vld_q       <= hold_vld_d;
      hold_data_q      <= hold_data_d;
      hold_last_q      <= hold_last_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign protocol_error = protocol_error_q;

`ifndef SYNTHESIS
  logic [31:0] cycle_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (violation)
        $error("axis_rr_arbiter: source %0d broke valid/data stability at cycle %0d", grant_q, cycle_q);
    end
  end
`endif
`else
  assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-source beat queues drive the inputs, a scoreboard checks output beats.
module tb_axis_rr_arbiter;

  localparam int DW = 10;
  localparam int NI = 4;
  localparam int SW = 2;
  localparam int MB = 4;
`ifdef AXIS_ARB_PROTOCOL_CHECK_EN
  localparam logic EXP_PERR = 1'b1;
`else
  localparam logic EXP_PERR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NI-1:0]    input_valid = '0;
  logic [NI*DW-1:0] input_data  = '0;
  logic [NI-1:0]    input_last  = '0;
  logic [NI-1:0]    input_ready;
  logic             output_valid;
  logic [DW-1:0]    output_data;
  logic             output_last;
  logic [SW-1:0]    output_source;
  logic             output_ready = 1'b1;
  logic             protocol_error;

  axis_rr_arbiter #(
    .DATA_WIDTH(DW), .NUM_INPUTS(NI), .SRC_WIDTH(SW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .input_valid(input_valid), .input_data(input_data), .input_last(input_last),
    .input_ready(input_ready),
    .output_valid(output_valid), .output_data(output_data), .output_last(output_last),
    .output_source(output_source), .output_ready(output_ready),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [DW-1:0] data; logic last; logic [SW-1:0] src; } exp_t;

  beat_t    src_q [NI][$];
  exp_t     sb [$];
  int       out_cyc [$];
  int       n_cmp = 0;
  int       n_err = 0;
  int       cyc = 0;
  int       pops = 0;
  int       bp_cnt = 0;
  bit       bp_en = 0;
  bit       bp_chk = 0;
  logic [NI-1:0] fire;
  exp_t     mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: timed out waiting for DUT", tag);
  endtask

  always @(posedge clk) cyc++;

  // Source model: pop the head when it was accepted, then present the next head.
  always begin
    @(negedge clk);
    fire = input_valid & input_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (fire[i] === 1'b1 && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        input_valid[i]            = 1'b1;
        input_data[i*DW +: DW]    = src_q[i][0].data;
        input_last[i]             = src_q[i][0].last;
      end else begin
        input_valid[i] = 1'b0;
        input_last[i]  = 1'b0;
      end
    end
  end

  // Output ready pattern 1,0,0,1,0,0,... while enabled.
  always begin
    @(posedge clk);
    #1;
    if (bp_en) begin
      output_ready = (bp_cnt % 3 == 0);
      bp_cnt++;
    end
  end

  // Scoreboard pop: a beat transfers at the next edge when valid and ready are both high now.
  always @(negedge clk) begin
    if (rst === 1'b0 && output_valid === 1'b1 && output_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_beat: observed data 0x%0h src %0d with nothing expected", output_data, output_source);
      end else begin
        mon_e = sb.pop_front();
        check("out_beat", 32'({output_data, output_last, output_source}), 32'(mon_e));
      end
      out_cyc.push_back(cyc);
      pops++;
    end
    if (bp_chk && output_valid === 1'b1 && output_ready === 1'b0)
      check("bp_ready_when_full", 32'(input_ready), 32'(0));
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input int s, input int n, input int base, input bit last_on_end);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = DW'(base + k);
      b.last = last_on_end && (k == n - 1);
      src_q[s].push_back(b);
    end
  endtask

  task automatic expect_beats(input int s, input int n, input int base, input bit last_on_end);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.data = DW'(base + k);
      e.last = last_on_end && (k == n - 1);
      e.src  = SW'(s);
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) src_q[i].delete();
    sb.delete();
    out_cyc.delete();
    pops = 0;
    #1;
    check("rst_output_valid",   32'(output_valid),   32'(0));
    check("rst_output_data",    32'(output_data),    32'(0));
    check("rst_output_last",    32'(output_last),    32'(0));
    check("rst_output_source",  32'(output_source),  32'(0));
    check("rst_input_ready",    32'(input_ready),    32'(0));
    check("rst_protocol_error", 32'(protocol_error), 32'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i;
    for (i = 0; i < budget && sb.size() != 0; i++) step();
    if (sb.size() != 0) timeout(tag);
    step(3);
  endtask

  int t_rise;
  int t_out;

  initial begin
    // Single source packet with first-beat latency.
    do_reset();
    send(2, 5, 'h001, 1'b1);
    expect_beats(2, 5, 'h001, 1'b1);
    for (int i = 0; i < 10 && input_valid[2] !== 1'b1; i++) @(negedge clk);
    t_rise = cyc;
    for (int i = 0; i < 10 && output_valid !== 1'b1; i++) @(negedge clk);
    t_out = cyc;
    check("first_beat_latency", 32'(t_out - t_rise), 32'(2));
    wait_drain("single_src", 60);

    // Round robin between 0, 1, 3 with one IDLE cycle between grants.
    do_reset();
    send(0, 1, 'h0A0, 1'b1);
    send(1, 1, 'h0A1, 1'b1);
    send(3, 1, 'h0A3, 1'b1);
    expect_beats(0, 1, 'h0A0, 1'b1);
    expect_beats(1, 1, 'h0A1, 1'b1);
    expect_beats(3, 1, 'h0A3, 1'b1);
    wait_drain("round_robin", 40);
    check("rr_beat_count", 32'(out_cyc.size()), 32'(3));
    if (out_cyc.size() == 3) begin
      check("rr_gap_0_1", 32'(out_cyc[1] - out_cyc[0]), 32'(2));
      check("rr_gap_1_3", 32'(out_cyc[2] - out_cyc[1]), 32'(2));
    end

    // Forced rotate after MAX_BURST beats without last.
    do_reset();
    send(0, 10, 'h100, 1'b0);
    send(1, 2, 'h200, 1'b1);
    expect_beats(0, 4, 'h100, 1'b0);
    expect_beats(1, 2, 'h200, 1'b1);
    expect_beats(0, 6, 'h104, 1'b0);
    wait_drain("forced_rotate", 80);

    // Backpressure on a 6-beat packet from source 3.
    do_reset();
    bp_cnt = 0;
    bp_en  = 1;
    bp_chk = 1;
    send(3, 6, 'h030, 1'b1);
    expect_beats(3, 6, 'h030, 1'b1);
    wait_drain("backpressure", 120);
    bp_en  = 0;
    bp_chk = 0;
    output_ready = 1'b1;

    // Reset in the middle of an 8-beat packet, then a single beat from source 2.
    do_reset();
    send(1, 8, 'h040, 1'b1);
    expect_beats(1, 8, 'h040, 1'b1);
    for (int i = 0; i < 50 && pops < 3; i++) @(negedge clk);
    if (pops < 3) timeout("mid_packet_beats");
    do_reset();
    send(2, 1, 'h055, 1'b1);
    expect_beats(2, 1, 'h055, 1'b1);
    wait_drain("post_reset_beat", 40);

    // Granted source changes data while stalled.
    do_reset();
    output_ready = 1'b0;
    send(0, 1, 'h011, 1'b0);
    send(0, 1, 'h0AA, 1'b1);
    expect_beats(0, 1, 'h011, 1'b0);
    expect_beats(0, 1, 'h0BB, 1'b1);
    for (int i = 0; i < 20 && output_valid !== 1'b1; i++) @(negedge clk);
    check("stall_ready_low", 32'(input_ready), 32'(0));
    check("stall_data_presented", 32'(input_data[0 +: DW]), 32'('h0AA));
    step();
    begin
      beat_t b;
      b = src_q[0].pop_front();
      b.data = DW'('h0BB);
      src_q[0].push_front(b);
    end
    step(3);
    check("protocol_error_set", 32'(protocol_error), 32'(EXP_PERR));
    output_ready = 1'b1;
    wait_drain("protocol_drain", 40);
    check("protocol_error_sticky", 32'(protocol_error), 32'(EXP_PERR));
    do_reset();
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
